// File: rtl/inst_mem_loader_pkg.sv
// Shared types and defaults for the instruction memory and its byte-stream loader.
package inst_mem_pkg;

    localparam int          DEFAULT_ADDR_W   = 8;
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/inst_mem_loader_if.sv
// Loader/fetch bus: the driver (host or pipeline) uses master, the memory uses slave.
interface inst_mem_loader_if #(
    parameter int ADDR_W = 8
) ();

    logic              prog_mode;
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              rx_ready;
    logic [31:0]       PC;
    logic [31:0]       Inst;
    logic              load_done;
    logic [ADDR_W:0]   word_count;
    logic              overflow;
    logic              misalign;

    modport master (
        output prog_mode, rx_valid, rx_byte, PC,
        input  rx_ready, Inst, load_done, word_count, overflow, misalign
    );

    modport slave (
        input  prog_mode, rx_valid, rx_byte, PC,
        output rx_ready, Inst, load_done, word_count, overflow, misalign
    );

endinterface

// File: rtl/inst_mem_loader_byte_assembler.sv
// Collects accepted bytes little-endian into a 32-bit word and reports word completion.
module byte_assembler (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  rx_byte,
    output logic [1:0]  byte_cnt,
    output logic        word_ready,
    output logic        partial,
    output logic [31:0] word_data,
    output logic [31:0] partial_data
);

    logic [31:0] assembly;

    // The register is zeroed after each completed word so a flushed partial word already has 0x00 padding.
    always_ff @(posedge CLK) begin
        if (!RESET || clear) begin
            byte_cnt <= 2'd0;
            assembly <= 32'd0;
        end else if (accept) begin
            if (byte_cnt == 2'd3) begin
                assembly <= 32'd0;
            end else begin
                assembly[{byte_cnt, 3'b000} +: 8] <= rx_byte;
            end
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    assign word_ready   = accept && (byte_cnt == 2'd3);
    assign word_data    = {rx_byte, assembly[23:0]};
    assign partial      = (byte_cnt != 2'd0);
    assign partial_data = assembly;

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction memory: loads a little-endian byte stream in prog_mode, otherwise serves registered fetches by PC.
module inst_mem_loader
    import inst_mem_pkg::*;
#(
    parameter int          ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input logic                CLK,
    input logic                RESET,
    inst_mem_loader_if.slave   bus
);

    localparam int              DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL  = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W:0]   word_count;
    logic [ADDR_W:0]   word_count_next;
    logic              rx_ready_q;
    logic              rx_ready_out;
    logic              overflow_q;
    logic [31:0]       inst_q;
    logic              misalign_q;
    logic [31:0]       mem [DEPTH];

    logic              accept;
    logic              full;
    logic              load_entry;
    logic              flush_write;
    logic              overflow_set;
    logic              word_write;
    logic [31:0]       write_data;
    logic              fetch_ok;

    logic [1:0]        byte_cnt;
    logic              word_ready;
    logic              partial;
    logic [31:0]       word_data;
    logic [31:0]       partial_data;

    byte_assembler u_assembler (
        .CLK          (CLK),
        .RESET        (RESET),
        .clear        (load_entry || (state == FLUSH)),
        .accept       (accept),
        .rx_byte      (bus.rx_byte),
        .byte_cnt     (byte_cnt),
        .word_ready   (word_ready),
        .partial      (partial),
        .word_data    (word_data),
        .partial_data (partial_data)
    );

    // Ready is gated by prog_mode so a byte offered as load mode drops is never taken.
    assign rx_ready_out = rx_ready_q && bus.prog_mode;
    assign accept       = bus.rx_valid && rx_ready_out;
    assign full         = (word_count == FULL);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, DONE: if (bus.prog_mode) next_state = LOAD;
            LOAD:       if (!bus.prog_mode) next_state = partial ? FLUSH : DONE;
            FLUSH:      next_state = DONE;
            default:    next_state = IDLE;
        endcase
    end

    always_comb begin
        load_entry   = 1'b0;
        flush_write  = 1'b0;
        overflow_set = 1'b0;
        unique case (state)
            IDLE, DONE: load_entry = bus.prog_mode;
            LOAD:       overflow_set = bus.prog_mode && bus.rx_valid && full;
            FLUSH: begin
                flush_write  = !full;
                overflow_set = full;
            end
            default: ;
        endcase
    end

    assign word_write = word_ready || flush_write;
    assign write_data = flush_write ? partial_data : word_data;

    always_comb begin
        word_count_next = word_count;
        if (load_entry) begin
            word_count_next = '0;
        end else if (word_write) begin
            word_count_next = word_count + 1'b1;
        end
    end

    // Ready looks at the post-edge count so the byte after the last word is already refused.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            word_count <= '0;
            rx_ready_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            word_count <= word_count_next;
            rx_ready_q <= (next_state == LOAD) && (word_count_next < FULL);
            overflow_q <= load_entry ? 1'b0 : (overflow_q || overflow_set);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET && word_write) begin
            mem[word_count[ADDR_W-1:0]] <= write_data;
        end
    end

    assign fetch_ok = !bus.prog_mode
                   && (state == DONE)
                   && (bus.PC[31:ADDR_W+2] == '0)
                   && (bus.PC[1:0] == 2'b00)
                   && ({1'b0, bus.PC[ADDR_W+1:2]} < word_count);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            inst_q     <= NOP_INST;
            misalign_q <= 1'b0;
        end else begin
            inst_q     <= fetch_ok ? mem[bus.PC[ADDR_W+1:2]] : NOP_INST;
            misalign_q <= (bus.PC[1:0] != 2'b00) && !bus.prog_mode;
        end
    end

    assign bus.rx_ready   = rx_ready_out;
    assign bus.Inst       = inst_q;
    assign bus.load_done  = (state == DONE);
    assign bus.word_count = word_count;
    assign bus.overflow   = overflow_q;
    assign bus.misalign   = misalign_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader with a small memory so that full/overflow is reachable.
module tb_inst_mem_loader;
    import inst_mem_pkg::*;

    localparam int          AW    = 2;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] NOP   = DEFAULT_NOP_INST;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
    } fetch_vec_t;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    always #5 CLK = ~CLK;

    inst_mem_loader_if #(.ADDR_W(AW)) bus ();

    inst_mem_loader #(.ADDR_W(AW), .NOP_INST(NOP)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    byte unsigned acc_q[$];
    logic [31:0] model_mem [DEPTH];
    int          model_wc   = 0;
    bit          model_ovf  = 1'b0;
    bit          model_done = 1'b0;
    fetch_vec_t  vecs [8];
    logic [31:0] first_word;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit pm, input bit v, input logic [7:0] b, input logic [31:0] pc);
        bus.prog_mode = pm;
        bus.rx_valid  = v;
        bus.rx_byte   = b;
        bus.PC        = pc;
    endtask

    // Word i of the current image: four accepted bytes little-endian, missing bytes read as zero.
    function automatic logic [31:0] model_word(input int i);
        logic [31:0] w = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (4 * i + k < acc_q.size()) w[8*k +: 8] = acc_q[4 * i + k];
        end
        return w;
    endfunction

    function automatic logic [31:0] expected_fetch(input logic [31:0] pc);
        if (model_done && (pc % 4 == 0) && ((pc / 4) < 32'(model_wc))) return model_mem[int'(pc / 4)];
        return NOP;
    endfunction

    task automatic start_load();
        applyStimulus(1'b1, 1'b0, 8'h00, 32'd0);
        tick();
        acc_q.delete();
        model_ovf  = 1'b0;
        model_done = 1'b0;
        checkOutput("entry_load_done", 32'(bus.load_done), 32'd0);
        checkOutput("entry_word_count", 32'(bus.word_count), 32'd0);
        checkOutput("entry_overflow", 32'(bus.overflow), 32'd0);
        checkOutput("blocked_fetch", bus.Inst, NOP);
    endtask

    task automatic send_byte(input bit v, input logic [7:0] b);
        bit exp_ready;
        exp_ready = (acc_q.size() < 4 * DEPTH);
        checkOutput("rx_ready", 32'(bus.rx_ready), 32'(exp_ready));
        bus.rx_valid = v;
        bus.rx_byte  = b;
        tick();
        if (v && exp_ready) acc_q.push_back(b);
        else if (v) model_ovf = 1'b1;
        checkOutput("live_word_count", 32'(bus.word_count), 32'(acc_q.size() / 4));
        checkOutput("live_overflow", 32'(bus.overflow), 32'(model_ovf));
    endtask

    task automatic end_load(input bit stray);
        bit v;
        v = stray && (acc_q.size() < 4 * DEPTH);
        applyStimulus(1'b0, v, 8'hEE, 32'd0);
        tick();
        bus.rx_valid = 1'b0;
        if (acc_q.size() % 4 != 0) begin
            checkOutput("flush_load_done", 32'(bus.load_done), 32'd0);
            checkOutput("flush_word_count", 32'(bus.word_count), 32'(acc_q.size() / 4));
            tick();
        end
        model_wc = (acc_q.size() + 3) / 4;
        if (model_wc > DEPTH) model_wc = DEPTH;
        for (int i = 0; i < model_wc; i++) model_mem[i] = model_word(i);
        model_done = 1'b1;
        checkOutput("done_load_done", 32'(bus.load_done), 32'd1);
        checkOutput("done_word_count", 32'(bus.word_count), 32'(model_wc));
        checkOutput("done_overflow", 32'(bus.overflow), 32'(model_ovf));
    endtask

    task automatic do_fetch(input logic [31:0] pc);
        bus.PC = pc;
        tick();
        checkOutput("fetch_inst", bus.Inst, expected_fetch(pc));
        checkOutput("fetch_misalign", 32'(bus.misalign), 32'(pc % 4 != 0));
    endtask

    task automatic check_reset_state(input string tag);
        checkOutput({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
        checkOutput({tag, "_load_done"}, 32'(bus.load_done), 32'd0);
        checkOutput({tag, "_word_count"}, 32'(bus.word_count), 32'd0);
        checkOutput({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
        checkOutput({tag, "_misalign"}, 32'(bus.misalign), 32'd0);
        checkOutput({tag, "_inst"}, bus.Inst, NOP);
    endtask

    initial begin
        vecs[0] = '{pc: 32'h0000_0000, inst: 32'h00A0_0513, mis: 1'b0};
        vecs[1] = '{pc: 32'h0000_0004, inst: 32'h0010_0593, mis: 1'b0};
        vecs[2] = '{pc: 32'h0000_0008, inst: NOP,           mis: 1'b0};
        vecs[3] = '{pc: 32'h0000_0002, inst: NOP,           mis: 1'b1};
        vecs[4] = '{pc: 32'h0000_1000, inst: NOP,           mis: 1'b0};
        vecs[5] = '{pc: 32'h0000_000C, inst: NOP,           mis: 1'b0};
        vecs[6] = '{pc: 32'h0000_0005, inst: NOP,           mis: 1'b1};
        vecs[7] = '{pc: 32'h0000_0010, inst: NOP,           mis: 1'b0};

        applyStimulus(1'b0, 1'b0, 8'h00, 32'd0);
        RESET = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        RESET = 1'b1;
        do_fetch(32'd0);

        start_load();
        foreach (vecs[i]) ;
        send_byte(1'b1, 8'h13);
        send_byte(1'b1, 8'h05);
        send_byte(1'b0, 8'h77);
        send_byte(1'b1, 8'hA0);
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h93);
        send_byte(1'b1, 8'h05);
        send_byte(1'b1, 8'h10);
        send_byte(1'b1, 8'h00);
        end_load(1'b1);
        checkOutput("basic_word_count", 32'(bus.word_count), 32'd2);
        for (int i = 0; i < 8; i++) begin
            bus.PC = vecs[i].pc;
            tick();
            checkOutput($sformatf("vec%0d_inst", i), bus.Inst, vecs[i].inst);
            checkOutput($sformatf("vec%0d_misalign", i), 32'(bus.misalign), 32'(vecs[i].mis));
        end

        start_load();
        send_byte(1'b1, 8'h37);
        send_byte(1'b1, 8'h01);
        send_byte(1'b1, 8'h00);
        end_load(1'b0);
        checkOutput("partial_word_count", 32'(bus.word_count), 32'd1);
        bus.PC = 32'd0;
        tick();
        checkOutput("partial_word", bus.Inst, 32'h0000_0137);

        start_load();
        for (int i = 0; i < 4 * DEPTH; i++) send_byte(1'b1, 8'(8'h40 + i));
        first_word = 32'h4342_4140;
        send_byte(1'b1, 8'hFF);
        checkOutput("full_overflow", 32'(bus.overflow), 32'd1);
        checkOutput("full_rx_ready", 32'(bus.rx_ready), 32'd0);
        end_load(1'b0);
        bus.PC = 32'd0;
        tick();
        checkOutput("full_word0", bus.Inst, first_word);
        for (int i = 1; i < DEPTH + 1; i++) do_fetch(32'(4 * i));
        start_load();
        end_load(1'b0);
        do_fetch(32'd0);

        start_load();
        for (int i = 0; i < 6; i++) send_byte(1'b1, 8'($urandom));
        RESET = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 32'd0);
        tick();
        check_reset_state("midload");
        RESET = 1'b1;
        acc_q.delete();
        model_wc   = 0;
        model_done = 1'b0;
        model_ovf  = 1'b0;
        do_fetch(32'd0);

        for (int r = 0; r < 12; r++) begin
            int n;
            start_load();
            n = $urandom_range(0, 4 * DEPTH + 4);
            for (int c = 0; c < n; c++) send_byte($urandom_range(0, 3) != 0, 8'($urandom));
            end_load(1'($urandom_range(0, 1)));
            for (int f = 0; f < 8; f++) begin
                logic [31:0] pc;
                case ($urandom_range(0, 2))
                    0:       pc = 32'(4 * $urandom_range(0, DEPTH - 1));
                    1:       pc = 32'($urandom_range(0, 4 * DEPTH + 3));
                    default: pc = $urandom;
                endcase
                do_fetch(pc);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Instruction memory with a byte-stream program loader.
- Sits directly upstream of the register/operand stage and supplies its 32-bit Inst word.
- While prog_mode=1: accepts a byte stream, assembles little-endian words and writes them sequentially from word 0.
- While prog_mode=0: serves instruction fetches by PC with one-cycle registered latency.

Parameters:
- ADDR_W, 8, word-address width; memory holds 2**ADDR_W words.
- NOP_INST, 32'h00000013, word returned for any invalid or blocked fetch.

Ports:
- CLK  in  1  single system clock; all logic on posedge.
- RESET  in  1  synchronous, active-low reset (0 = reset), sampled on posedge CLK.
- prog_mode  in  1  1 = load mode; fetch is blocked.
- rx_valid  in  1  rx_byte is valid this cycle.
- rx_byte  in  8  incoming program byte.
- rx_ready  out  1  loader can accept a byte; a transfer occurs when rx_valid & rx_ready.
- PC  in  32  fetch byte address.
- Inst  out  32  fetched instruction, registered.
- load_done  out  1  last load completed; image valid.
- word_count  out  ADDR_W+1  number of words written by the last or current load.
- overflow  out  1  sticky: a byte arrived while memory was full.
- misalign  out  1  registered alongside Inst: the fetch had PC[1:0] != 0.

Behaviour:
- Reset (RESET=0 at posedge):
  - state=IDLE; rx_ready=0, load_done=0, word_count=0, overflow=0, misalign=0; Inst=NOP_INST.
  - Byte counter and assembly register are cleared.
  - Memory contents are not cleared; word_count=0 makes every fetch return NOP.
  - Reset overrides everything, including mid-load: a partial word is discarded and no flush happens.
- States: IDLE, LOAD, FLUSH, DONE.
  - IDLE/DONE -> LOAD when prog_mode=1 (level). On entry: word_count=0, byte_cnt=0, overflow=0, load_done=0.
  - LOAD -> FLUSH when prog_mode falls and byte_cnt != 0.
  - LOAD -> DONE when prog_mode falls and byte_cnt == 0.
  - FLUSH -> DONE after exactly 1 cycle.
  - DONE: load_done=1, held until the next LOAD entry.
- LOAD:
  - rx_ready = (word_count < 2**ADDR_W), registered, updated every cycle.
  - On each accepted byte: assembly[8*byte_cnt +: 8] = rx_byte; byte_cnt increments mod 4.
  - When byte_cnt==3 and a byte is accepted, the completed word is written to mem[word_count] that same edge, word_count increments, and byte_cnt wraps to 0.
  - Byte order is little-endian: the first byte is Inst[7:0].
  - Full (word_count == 2**ADDR_W): rx_ready=0. Any rx_valid=1 while full sets overflow, which stays sticky until the next LOAD entry. The byte is dropped.
- FLUSH: writes the partial word with unfilled bytes set to 0x00 to mem[word_count]; word_count increments. If memory is already full, there is no write and overflow is set.
- A byte presented in the same cycle prog_mode falls is not accepted: rx_ready is 0 whenever prog_mode=0.
- Fetch:
  - Each posedge, Inst <= mem[PC[ADDR_W+1:2]] if all of the following hold:
    - prog_mode=0;
    - state is DONE;
    - PC[31:ADDR_W+2] == 0;
    - PC[1:0] == 0;
    - PC[ADDR_W+1:2] < word_count.
  - Otherwise Inst <= NOP_INST.
  - misalign <= (PC[1:0] != 0) & ~prog_mode.
  - Latency: exactly 1 cycle from PC to Inst.
- Load write and fetch never coincide, because fetch is blocked in prog_mode and in FLUSH.
- word_count arithmetic is unsigned ADDR_W+1 bits and never exceeds 2**ADDR_W.

Decomposition:
- Package inst_mem_pkg: state enum (IDLE, LOAD, FLUSH, DONE), NOP_INST constant, default ADDR_W.
- One sub-module, byte_assembler: byte_cnt, assembly register, word_ready/flush outputs, fully synchronous.
- The parent owns the FSM, memory array, word_count and fetch path.

Test Plan:
- Reset then fetch: RESET=0 for 2 cycles, release, PC=0 -> Inst=32'h00000013; load_done=0, word_count=0.
- Basic load and fetch:
  - Stimulus: prog_mode=1; stream 13 05 A0 00 93 05 10 00; prog_mode=0.
  - Response: load_done=1, word_count=2.
  - Fetch: PC=0 -> Inst=32'h00A00513 next cycle; PC=4 -> 32'h00100593; PC=8 -> NOP.
- Partial flush: load bytes 37 01 00 then prog_mode=0 -> FLUSH 1 cycle, word_count=1; PC=0 -> Inst=32'h00000137.
- Full/overflow:
  - Stimulus: ADDR_W=2; load 16 bytes, then a 17th with rx_valid=1.
  - Response: rx_ready=0 after word 4; overflow=1; mem[0] unchanged; word_count=4.
  - Next LOAD entry clears overflow.
- Misaligned/out-of-range: after a 2-word load, PC=2 -> Inst=NOP, misalign=1; PC=32'h00001000 -> NOP, misalign=0.
- Reset mid-load: 6 bytes accepted, then RESET=0 one cycle -> word_count=0, load_done=0; fetch PC=0 -> NOP.
